ram_arbiter: RTL

- Shares the external asynchronous cellular RAM between two requesters.
  - Audio playback read port: the 31.5 kHz sample fetch.
  - Record/load write port.
- Sequences each access as a timed async cycle with registered strobes, a fixed wait count and a recovery cycle.
- Sits between the audio sample sequencer and the board RAM pins, and owns MemAdr, MemDB and all Ram/Mem control strobes.

---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_cycle_timer.sv | 29 ++
 rtl/ram_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the cellular-RAM arbiter: FSM states, grant
// identifiers and the registered strobe patterns driven onto the RAM pins.
package ram_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;
  typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

  // Strobe vector order: {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}.
  localparam logic [6:0] STROBE_IDLE  = 7'b101_1111;
  localparam logic [6:0] STROBE_READ  = 7'b000_0100;
  localparam logic [6:0] STROBE_WRITE = 7'b000_1000;

  localparam int WAIT_CYCLES_DEFAULT = 6;

  function automatic logic [6:0] strobe_for(input state_t s);
    case (s)
      READ:    return STROBE_READ;
      WRITE:   return STROBE_WRITE;
      default: return STROBE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ram_cycle_timer.sv
// Loadable down-counter shared by the strobe-wait and recovery phases;
// done is high while the count sits at zero.
module ram_cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the async cellular RAM between the audio read
// port and the record/load write port, sequencing fully registered strobes.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int WAIT_CYCLES    = WAIT_CYCLES_DEFAULT,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic [26:1]       MemAdr,
  inout  wire  [15:0]       MemDB,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB
);

  localparam int MAX_CYC = (WAIT_CYCLES > RECOVER_CYCLES) ? WAIT_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC) > 3) ? $clog2(MAX_CYC) : 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);

  state_t           state, state_next;
  grant_t           last_grant;
  logic             grant_rd, grant_wr;
  logic             timer_load, timer_done;
  logic [CNT_W-1:0] timer_val;
  logic             capture, capture_d;
  logic             drive;
  logic [15:0]      wdata_q;
  logic [6:0]       strobe_q;

  ram_cycle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    timer_load = 1'b0;
    timer_val  = WAIT_LOAD;
    unique case (state)
      IDLE: begin
        // On a tie the port that did not win last time is served.
        if (rd_req && (!wr_req || last_grant == GRANT_WR)) grant_rd = 1'b1;
        else if (wr_req)                                   grant_wr = 1'b1;
        if (grant_rd)      state_next = READ;
        else if (grant_wr) state_next = WRITE;
        timer_load = grant_rd | grant_wr;
      end
      READ, WRITE: begin
        if (timer_done) begin
          state_next = RECOVER;
          timer_load = 1'b1;
          timer_val  = RECOVER_LOAD;
        end
      end
      RECOVER: begin
        if (timer_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture = (state == READ) && timer_done;

  // NOTE: the latched address/data registers are reset along with control so a
  // reset mid-access leaves nothing stale on MemAdr or the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_WR;
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      capture_d  <= 1'b0;
      MemAdr     <= '0;
      wdata_q    <= '0;
      drive      <= 1'b0;
      strobe_q   <= STROBE_IDLE;
    end else begin
      state     <= state_next;
      strobe_q  <= strobe_for(state_next);
      drive     <= (state_next == WRITE);
      rd_ack    <= grant_rd;
      wr_ack    <= grant_wr;
      capture_d <= capture;
      rd_valid  <= capture_d;
      if (grant_rd || grant_wr) begin
        MemAdr     <= 26'(grant_rd ? rd_addr : wr_addr);
        last_grant <= grant_rd ? GRANT_RD : GRANT_WR;
      end
      if (grant_wr) wdata_q <= wr_data;
      if (capture)  rd_data <= MemDB;
    end
  end

  assign busy  = (state != IDLE);
  assign MemDB = drive ? wdata_q : 16'hzzzz;
  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = strobe_q;

endmodule
